except_ctrl: RTL and testbench
==============================

EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-002 Ports (name dir width meaning):
- clk in 1 clock
- rst in 1 synchronous active-high reset
- stall_i in 1 MEM stage stalled
- valid_i in 1 MEM holds a real instruction
- pc_i in 32 MEM instruction address
- in_dslot_i in 1 MEM instruction is in a delay slot
- exc_flags_i in 6 {eret, break, syscall, ov, ri, if_adel}
- mem_rd_i in 1 load
- mem_wr_i in 1 store
- mem_size_i in 2 0=byte, 1=half, 2=word
- mem_addr_i in 32 data address
- cp0_status_i in 32 CP0 Status
- cp0_cause_i in 32 CP0 Cause
- cp0_epc_i in 32 CP0 EPC
- wb_cp0_we_i in 1 WB-stage CP0 write enable
- wb_cp0_addr_i in 5 WB-stage CP0 write address
- wb_cp0_data_i in 32 WB-stage CP0 write data
- excepttype_o out 32 exception code to CP0
- cur_addr_o out 32 faulting PC to CP0
- in_dslot_o out 1 delay-slot flag to CP0
- bad_addr_o out 32 BadVAddr value to CP0
- flush_o out 1 pipeline flush
- newpc_o out 32 redirect target
- exc_count_o out 32 number of exceptions taken

Function
REQ-003 Status, Cause and EPC SHALL be bypassed: when wb_cp0_we_i=1 and wb_cp0_addr_i is 12, 13 or 14, wb_cp0_data_i SHALL replace the corresponding input. For Cause, only bits 9:8 SHALL be replaced.
REQ-004 The interrupt-pending register int_pend SHALL be set when (Status[15:8] & Cause[15:8]) != 0, Status[0]=1 and Status[1]=0, and SHALL be cleared when that condition is false or an exception is taken.
REQ-005 An instruction SHALL be eligible for exception detection when valid_i=1, stall_i=0 and state=IDLE.
REQ-006 For an eligible instruction, the exception code SHALL be chosen by this priority: int_pend → 0x1; if_adel → 0x4 with bad_addr=pc_i; ri → 0xa; ov → 0xc; syscall → 0x8; break → 0x9; data AdEL → 0x4; data AdES → 0x5; eret → 0xe; otherwise 0x0.
REQ-007 A misaligned access SHALL be detected when size=half and addr[0]!=0, or size=word and addr[1:0]!=0. A misaligned load SHALL raise AdEL and a misaligned store SHALL raise AdES, and in both cases bad_addr_o SHALL equal mem_addr_i.
REQ-008 excepttype_o, cur_addr_o, in_dslot_o, bad_addr_o, flush_o and newpc_o SHALL be combinational, so that CP0 samples them on the same clk edge.
REQ-009 flush_o SHALL be 1 when excepttype_o != 0.
REQ-010 newpc_o SHALL equal the bypassed EPC for code 0xe and SHALL equal 0xBFC00380 for any other nonzero code.
REQ-011 When no exception is raised, excepttype_o, bad_addr_o, flush_o and newpc_o SHALL be 0.
REQ-012 The state machine SHALL have two states, IDLE and SQUASH:
- IDLE goes to SQUASH on a clock edge where flush_o=1.
- SQUASH goes to IDLE after exactly one cycle, regardless of stall_i.
- While in SQUASH, the MEM instruction SHALL be ignored (no exception, flush_o=0).
REQ-013 exc_count_o SHALL increment by 1 on each edge where the code is nonzero and not 0xe, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-014 If stall_i=1 while an exception condition is present, no exception SHALL be raised, and int_pend SHALL hold its value until the stall clears.

Reset
REQ-015 When rst=1, state SHALL be IDLE, int_pend SHALL be 0 and exc_count_o SHALL be 0, and all combinational outputs SHALL be forced to 0.
REQ-016 A reset asserted while in SQUASH SHALL return state to IDLE on that edge with no further squash cycle.

Configuration
REQ-017 When the macro EXCEPT_CTRL_ADDR_CHECK_EN is defined, data AdEL and AdES detection per REQ-007 SHALL be included.
REQ-018 When EXCEPT_CTRL_ADDR_CHECK_EN is undefined, data AdEL and AdES SHALL never be raised, while fetch AdEL (if_adel) SHALL remain active.

Verification
REQ-019 Syscall case: syscall at pc=0xBFC00100 with in_dslot=1 → excepttype=0x8, cur_addr=0xBFC00100, in_dslot_o=1, flush=1, newpc=0xBFC00380, exc_count=1.
REQ-020 Misaligned store case: sw to addr 0x80000002 → code 0x5 and bad_addr=0x80000002. With the macro undefined → code 0x0.
REQ-021 ERET bypass case: eret in MEM while WB writes EPC=0xBFC00200 → code 0xe, newpc=0xBFC00200, exc_count unchanged.
REQ-022 Interrupt plus RI case: Status=0x0000FF01, Cause[15:8]=0x04, RI flagged → code 0x1. The instruction in the next cycle is squashed, and flush=0 in that cycle.
REQ-023 Stall case: break present with stall_i=1 for 3 cycles → no flush during the stall; when stall_i drops → code 0x9.
REQ-024 Counter wrap case: exc_count preset to 0xFFFFFFFF, then one overflow exception → code 0xc and exc_count=0.

Source files
------------

// File: rtl/except_ctrl.sv
// Exception controller for the MEM stage: detects and prioritises exceptions, drives CP0 and redirects fetch.
// Build option: define EXCEPT_CTRL_ADDR_CHECK_EN to include data-address misalignment (AdEL/AdES) detection.
module except_ctrl #(
    parameter logic [31:0] EXC_COUNT_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_dslot_i,
    input  logic [5:0]  exc_flags_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_addr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cur_addr_o,
    output logic        in_dslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic [31:0] exc_count_o
);

    localparam logic [4:0]  CP0_STATUS = 5'd12;
    localparam logic [4:0]  CP0_CAUSE  = 5'd13;
    localparam logic [4:0]  CP0_EPC    = 5'd14;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        int_pend_q, int_pend_d;
    logic [31:0] exc_count_q, exc_count_d;

    logic [31:0] status_byp, cause_byp, epc_byp;
    logic        int_cond;
    logic        eligible;
    logic        data_adel, data_ades;
    logic [31:0] code;
    logic [31:0] bad_addr;
    logic        unused_bits;

    logic f_eret, f_break, f_syscall, f_ov, f_ri, f_if_adel;
    assign {f_eret, f_break, f_syscall, f_ov, f_ri, f_if_adel} = exc_flags_i;

    // CP0 write still in WB must be visible to the instruction now in MEM.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        status_byp = cp0_status_i;
        cause_byp  = cp0_cause_i;
        epc_byp    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_addr_i == CP0_STATUS) status_byp      = wb_cp0_data_i;
            if (wb_cp0_addr_i == CP0_CAUSE)  cause_byp[9:8]  = wb_cp0_data_i[9:8];
            if (wb_cp0_addr_i == CP0_EPC)    epc_byp         = wb_cp0_data_i;
        end
    end

    assign int_cond = (|(status_byp[15:8] & cause_byp[15:8])) && status_byp[0] && !status_byp[1];

`ifdef EXCEPT_CTRL_ADDR_CHECK_EN
    logic addr_misaligned;

    always_comb begin
        addr_misaligned = 1'b0;
        case (mem_size_i)
            2'd1:    addr_misaligned = mem_addr_i[0];
            2'd2:    addr_misaligned = |mem_addr_i[1:0];
            default: addr_misaligned = 1'b0;
        endcase
    end

    assign data_adel   = mem_rd_i & addr_misaligned;
    assign data_ades   = mem_wr_i & addr_misaligned;
    assign unused_bits = ^{status_byp[31:16], status_byp[7:2], cause_byp[31:16], cause_byp[7:0]};
`else
    assign data_adel   = 1'b0;
    assign data_ades   = 1'b0;
    assign unused_bits = ^{status_byp[31:16], status_byp[7:2], cause_byp[31:16], cause_byp[7:0],
                           mem_rd_i, mem_wr_i, mem_size_i, mem_addr_i};
`endif

    assign eligible = !rst && valid_i && !stall_i && (state_q == IDLE);

    always_comb begin
        code     = EXC_NONE;
        bad_addr = 32'h0;
        if (eligible) begin
            if (int_pend_q) begin
                code = EXC_INT;
            end else if (f_if_adel) begin
                code     = EXC_ADEL;
                bad_addr = pc_i;
            end else if (f_ri) begin
                code = EXC_RI;
            end else if (f_ov) begin
                code = EXC_OV;
            end else if (f_syscall) begin
                code = EXC_SYS;
            end else if (f_break) begin
                code = EXC_BP;
            end else if (data_adel) begin
                code     = EXC_ADEL;
                bad_addr = mem_addr_i;
            end else if (data_ades) begin
                code     = EXC_ADES;
                bad_addr = mem_addr_i;
            end else if (f_eret) begin
                code = EXC_ERET;
            end
        end
    end

    // Outputs stay combinational so CP0 latches them on the same edge the exception is taken.
    assign excepttype_o = code;
    assign flush_o      = (code != EXC_NONE);
    assign bad_addr_o   = bad_addr;
    assign cur_addr_o   = flush_o ? pc_i : 32'h0;
    assign in_dslot_o   = flush_o & in_dslot_i;
    assign newpc_o      = (code == EXC_ERET) ? epc_byp :
                          (flush_o ? EXC_VECTOR : 32'h0);
    assign exc_count_o  = exc_count_q;

    always_comb begin
        state_d     = state_q;
        int_pend_d  = int_pend_q;
        exc_count_d = exc_count_q;

        unique case (state_q)
            IDLE:   state_d = flush_o ? SQUASH : IDLE;
            SQUASH: state_d = IDLE;
        endcase

        // A taken exception consumes the interrupt; a stalled MEM stage freezes it.
        if (flush_o) begin
            int_pend_d = 1'b0;
        end else if (!stall_i) begin
            int_pend_d = int_cond;
        end

        if (flush_o && (code != EXC_ERET)) begin
            exc_count_d = exc_count_q + 32'd1;
        end

        if (rst) begin
            state_d     = IDLE;
            int_pend_d  = 1'b0;
            exc_count_d = EXC_COUNT_RST;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        int_pend_q  <= int_pend_d;
        exc_count_q <= exc_count_d;
    end

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: per-cycle expectations go through a scoreboard queue.
// A second instance with a preset counter exercises the exception-count wrap.
module tb_except_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, valid, in_dslot, mem_rd, mem_wr, wb_we;
    logic [31:0] pc, mem_addr, status, cause, epc, wb_data;
    logic [5:0]  flags;
    logic [1:0]  mem_size;
    logic [4:0]  wb_addr;

    logic [31:0] ex_type, cur_addr, bad_addr, newpc, exc_count;
    logic        dslot_o, flush;

    logic        w_valid;
    logic [5:0]  w_flags;
    logic [31:0] w_type, w_cur, w_bad, w_newpc, w_count;
    logic        w_dslot, w_flush;

    localparam logic [5:0] F_ERET = 6'b100000;
    localparam logic [5:0] F_BRK  = 6'b010000;
    localparam logic [5:0] F_SYS  = 6'b001000;
    localparam logic [5:0] F_OV   = 6'b000100;
    localparam logic [5:0] F_RI   = 6'b000010;
    localparam logic [5:0] F_IADE = 6'b000001;

`ifdef EXCEPT_CTRL_ADDR_CHECK_EN
    localparam bit ADDR_CHK = 1'b1;
`else
    localparam bit ADDR_CHK = 1'b0;
`endif

    except_ctrl dut (
        .clk(clk), .rst(rst), .stall_i(stall), .valid_i(valid), .pc_i(pc),
        .in_dslot_i(in_dslot), .exc_flags_i(flags), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .mem_size_i(mem_size), .mem_addr_i(mem_addr), .cp0_status_i(status),
        .cp0_cause_i(cause), .cp0_epc_i(epc), .wb_cp0_we_i(wb_we), .wb_cp0_addr_i(wb_addr),
        .wb_cp0_data_i(wb_data), .excepttype_o(ex_type), .cur_addr_o(cur_addr),
        .in_dslot_o(dslot_o), .bad_addr_o(bad_addr), .flush_o(flush), .newpc_o(newpc),
        .exc_count_o(exc_count)
    );

    except_ctrl #(.EXC_COUNT_RST(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .rst(rst), .stall_i(stall), .valid_i(w_valid), .pc_i(pc),
        .in_dslot_i(in_dslot), .exc_flags_i(w_flags), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .mem_size_i(mem_size), .mem_addr_i(mem_addr), .cp0_status_i(status),
        .cp0_cause_i(cause), .cp0_epc_i(epc), .wb_cp0_we_i(wb_we), .wb_cp0_addr_i(wb_addr),
        .wb_cp0_data_i(wb_data), .excepttype_o(w_type), .cur_addr_o(w_cur),
        .in_dslot_o(w_dslot), .bad_addr_o(w_bad), .flush_o(w_flush), .newpc_o(w_newpc),
        .exc_count_o(w_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] code;
        logic [31:0] bad;
        logic [31:0] newpc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_cnt  = 32'h0;
    string       step     = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s/%s: got %h, expected %h", step, tag, got, want);
    endtask

    function automatic exp_t ex(input logic [31:0] code, input logic [31:0] bad, input logic [31:0] tgt);
        exp_t e;
        e.code  = code;
        e.bad   = bad;
        e.newpc = (code == 32'h0) ? 32'h0 : ((code == 32'he) ? tgt : 32'hBFC0_0380);
        return e;
    endfunction

    function automatic exp_t none();
        return ex(32'h0, 32'h0, 32'h0);
    endfunction

    // One MEM cycle: push the expectation, sample before the edge, then step to the next negedge.
    task automatic cyc(input exp_t e);
        exp_t w;
        exp_q.push_back(e);
        #2;
        w = exp_q.pop_front();
        check("code",  ex_type, w.code);
        check("flush", {31'b0, flush}, {31'b0, (w.code != 32'h0)});
        check("newpc", newpc, w.newpc);
        check("bad",   bad_addr, w.bad);
        check("count", exc_count, exp_cnt);
        if (w.code != 32'h0) begin
            check("cur_addr", cur_addr, pc);
            check("dslot", {31'b0, dslot_o}, {31'b0, in_dslot});
        end
        if (rst) exp_cnt = 32'h0;
        else if (w.code != 32'h0 && w.code != 32'he) exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
    endtask

    task automatic clr();
        rst = 1'b0; stall = 1'b0; valid = 1'b0; in_dslot = 1'b0; flags = 6'h0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_size = 2'd0; mem_addr = 32'h0; pc = 32'h0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; w_valid = 1'b0; w_flags = 6'h0;
    endtask

    task automatic instr(input logic [31:0] a, input logic [5:0] f);
        valid = 1'b1; pc = a; flags = f;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        status = 32'h0; cause = 32'h0; epc = 32'h0;
        rst = 1'b1;
        instr(32'h0000_1000, F_SYS);
        @(posedge clk);
        @(negedge clk);

        step = "reset";
        #1;
        check("cur_addr", cur_addr, 32'h0);
        check("dslot", {31'b0, dslot_o}, 32'h0);
        check("wrap_preset", w_count, 32'hFFFF_FFFF);
        cyc(none());
        cyc(none());

        step = "syscall";
        clr(); instr(32'hBFC0_0100, F_SYS); in_dslot = 1'b1;
        w_valid = 1'b1; w_flags = F_OV;
        #1;
        check("wrap_code", w_type, 32'hc);
        check("wrap_flush", {31'b0, w_flush}, 32'h1);
        check("wrap_newpc", w_newpc, 32'hBFC0_0380);
        check("wrap_bad", w_bad, 32'h0);
        check("wrap_cur", w_cur, 32'hBFC0_0100);
        check("wrap_dslot", {31'b0, w_dslot}, 32'h1);
        check("wrap_cnt_pre", w_count, 32'hFFFF_FFFF);
        cyc(ex(32'h8, 32'h0, 32'h0));

        step = "squash_after_sys";
        w_valid = 1'b0; w_flags = 6'h0;
        #1;
        check("wrap_cnt_post", w_count, 32'h0);
        check("wrap_code_sq", w_type, 32'h0);
        cyc(none());

        step = "idle";
        clr();
        cyc(none());

        step = "sw_misaligned";
        clr(); instr(32'h0000_2000, 6'h0); mem_wr = 1'b1; mem_size = 2'd2; mem_addr = 32'h8000_0002;
        cyc(ADDR_CHK ? ex(32'h5, 32'h8000_0002, 32'h0) : none());
        clr(); cyc(none());

        step = "lh_misaligned";
        clr(); instr(32'h0000_2004, 6'h0); mem_rd = 1'b1; mem_size = 2'd1; mem_addr = 32'h0000_0001;
        cyc(ADDR_CHK ? ex(32'h4, 32'h0000_0001, 32'h0) : none());
        clr(); cyc(none());

        step = "aligned_ok";
        clr(); instr(32'h0000_2008, 6'h0); mem_rd = 1'b1; mem_size = 2'd2; mem_addr = 32'h0000_0004;
        cyc(none());
        clr(); instr(32'h0000_200c, 6'h0); mem_wr = 1'b1; mem_size = 2'd0; mem_addr = 32'h0000_0003;
        cyc(none());

        step = "if_adel_over_ri";
        clr(); instr(32'h0000_2001, F_IADE | F_RI);
        cyc(ex(32'h4, 32'h0000_2001, 32'h0));
        clr(); cyc(none());

        step = "ov_over_sys";
        clr(); instr(32'h0000_3000, F_OV | F_SYS | F_BRK);
        cyc(ex(32'hc, 32'h0, 32'h0));
        clr(); cyc(none());

        step = "break";
        clr(); instr(32'h0000_3004, F_BRK | F_ERET);
        cyc(ex(32'h9, 32'h0, 32'h0));
        clr(); cyc(none());

        step = "eret_bypass";
        clr(); epc = 32'h1234_5678; instr(32'h0000_3008, F_ERET);
        wb_we = 1'b1; wb_addr = 5'd14; wb_data = 32'hBFC0_0200;
        cyc(ex(32'he, 32'h0, 32'hBFC0_0200));
        clr(); cyc(none());

        step = "eret_plain";
        clr(); instr(32'h0000_300c, F_ERET);
        cyc(ex(32'he, 32'h0, 32'h1234_5678));
        clr(); cyc(none());

        step = "int_setup";
        clr(); status = 32'h0000_FF01; cause = 32'h0000_0400;
        cyc(none());
        step = "int_over_ri";
        instr(32'h0000_4000, F_RI);
        cyc(ex(32'h1, 32'h0, 32'h0));
        step = "int_squash";
        status = 32'h0;
        cyc(none());
        step = "ri_after_int";
        cyc(ex(32'ha, 32'h0, 32'h0));
        clr(); cyc(none());

        step = "int_masked_exl";
        clr(); status = 32'h0000_FF03; cause = 32'h0000_0400;
        cyc(none());
        instr(32'h0000_4004, F_SYS);
        cyc(ex(32'h8, 32'h0, 32'h0));
        clr(); status = 32'h0; cause = 32'h0; cyc(none());

        step = "cause_bypass_sw";
        clr(); status = 32'h0000_FF01; cause = 32'h0;
        wb_we = 1'b1; wb_addr = 5'd13; wb_data = 32'h0000_0100;
        cyc(none());
        wb_we = 1'b0; instr(32'h0000_4008, 6'h0);
        cyc(ex(32'h1, 32'h0, 32'h0));
        clr(); status = 32'h0; cyc(none());

        step = "cause_bypass_hw_bits";
        clr(); status = 32'h0000_FF01; cause = 32'h0;
        wb_we = 1'b1; wb_addr = 5'd13; wb_data = 32'h0000_0400;
        cyc(none());
        wb_we = 1'b0; instr(32'h0000_400c, 6'h0);
        cyc(none());
        clr(); status = 32'h0; cyc(none());

        step = "status_bypass";
        clr(); status = 32'h0; cause = 32'h0000_0400;
        wb_we = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000_FF01;
        cyc(none());
        wb_we = 1'b0; instr(32'h0000_4010, 6'h0);
        cyc(ex(32'h1, 32'h0, 32'h0));
        clr(); cause = 32'h0; cyc(none());

        step = "int_held_in_stall";
        clr(); status = 32'h0000_FF01; cause = 32'h0000_0400;
        cyc(none());
        status = 32'h0; stall = 1'b1; instr(32'h0000_5000, F_RI);
        cyc(none());
        cyc(none());
        stall = 1'b0;
        cyc(ex(32'h1, 32'h0, 32'h0));
        clr(); cause = 32'h0; cyc(none());

        step = "break_stalled";
        clr(); stall = 1'b1; instr(32'h0000_5004, F_BRK);
        for (int i = 0; i < 3; i++) cyc(none());
        step = "break_released";
        stall = 1'b0;
        cyc(ex(32'h9, 32'h0, 32'h0));
        clr(); cyc(none());

        step = "rst_in_squash";
        clr(); instr(32'h0000_6000, F_SYS);
        cyc(ex(32'h8, 32'h0, 32'h0));
        rst = 1'b1;
        cyc(none());
        rst = 1'b0;
        step = "after_rst";
        cyc(ex(32'h8, 32'h0, 32'h0));
        clr(); cyc(none());

        step = "squash_ignores_stall";
        clr(); instr(32'h0000_7000, F_SYS);
        cyc(ex(32'h8, 32'h0, 32'h0));
        stall = 1'b1;
        cyc(none());
        stall = 1'b0;
        cyc(ex(32'h8, 32'h0, 32'h0));
        clr(); cyc(none());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
